// File: rtl/packet_transmitter_if.sv
// AXI-Stream beat bundle (512-bit data) shared by the cable stream and the
// compare-FIFO copy stream.
interface packet_transmitter_if;
  logic [511:0] tdata;
  logic [63:0]  tkeep;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/packet_transmitter.sv
// Cable-test packet generator: one deterministic 512-bit beat stream presented
// on two AXI-Stream outputs; a beat retires only once both have accepted it.
module packet_transmitter #(
  parameter int LEN_WIDTH = 16,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] packet_len,
  input  logic [CNT_WIDTH-1:0] packet_count,
  input  logic [31:0]          seed,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] packets_sent,
  packet_transmitter_if.master axis_out,
  packet_transmitter_if.master axis_fifo_out
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [0:0]           state_r;
  logic [LEN_WIDTH-1:0] len_r;
  logic [CNT_WIDTH-1:0] count_r;
  logic [CNT_WIDTH-1:0] packets_sent_r;
  logic [LEN_WIDTH-1:0] beat_idx_r;
  logic [31:0]          word_r;
  logic [511:0]         tdata_r;
  logic                 tlast_r;
  logic                 out_pend_r;
  logic                 fifo_pend_r;
  logic                 stop_pend_r;

  logic                 retire_s;
  logic                 last_retire_s;
  logic                 done_s;
  logic [LEN_WIDTH-1:0] next_idx_s;

  function automatic logic [511:0] beat_pattern(input logic [31:0] w);
    logic [511:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      r[32*k +: 32] = w + 32'(k);
    end
    return r;
  endfunction

  // Retire/completion decode: a beat retires once every still-pending stream handshakes.
  always_comb begin
    retire_s      = 1'b0;
    last_retire_s = 1'b0;
    done_s        = 1'b0;
    next_idx_s    = '0;
    if (state_r == ST_RUN) begin
      retire_s = (!out_pend_r || axis_out.tready) && (!fifo_pend_r || axis_fifo_out.tready);
    end else begin
      retire_s = 1'b0;
    end
    last_retire_s = retire_s && tlast_r;
    // stop arriving with the final retire still ends the run at that retire
    done_s = last_retire_s &&
             (((count_r != '0) && ((packets_sent_r + CNT_ONE) == count_r)) || stop_pend_r || stop);
    if (tlast_r) begin
      next_idx_s = '0;
    end else begin
      next_idx_s = beat_idx_r + LEN_ONE;
    end
  end

  // Run control FSM plus the shared beat register and per-stream pending flags.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r        <= ST_IDLE;
      len_r          <= LEN_ONE;
      count_r        <= '0;
      packets_sent_r <= '0;
      beat_idx_r     <= '0;
      word_r         <= 32'd0;
      tdata_r        <= '0;
      tlast_r        <= 1'b0;
      out_pend_r     <= 1'b0;
      fifo_pend_r    <= 1'b0;
      stop_pend_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            len_r          <= (packet_len == '0) ? LEN_ONE : packet_len;
            count_r        <= packet_count;
            packets_sent_r <= '0;
            stop_pend_r    <= 1'b0;
            beat_idx_r     <= '0;
            tdata_r        <= beat_pattern(seed);
            tlast_r        <= (packet_len <= LEN_ONE);
            word_r         <= seed + 32'd16;
            out_pend_r     <= 1'b1;
            fifo_pend_r    <= 1'b1;
            state_r        <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (stop) begin
            stop_pend_r <= 1'b1;
          end
          if (out_pend_r && axis_out.tready) begin
            out_pend_r <= 1'b0;
          end
          if (fifo_pend_r && axis_fifo_out.tready) begin
            fifo_pend_r <= 1'b0;
          end
          if (last_retire_s) begin
            packets_sent_r <= packets_sent_r + CNT_ONE;
          end
          if (done_s) begin
            state_r     <= ST_IDLE;
            out_pend_r  <= 1'b0;
            fifo_pend_r <= 1'b0;
            tlast_r     <= 1'b0;
          end else if (retire_s) begin
            // next beat loads in the retire cycle so both-ready streams run at one beat per clock
            beat_idx_r  <= next_idx_s;
            tdata_r     <= beat_pattern(word_r);
            tlast_r     <= (next_idx_s == (len_r - LEN_ONE));
            word_r      <= word_r + 32'd16;
            out_pend_r  <= 1'b1;
            fifo_pend_r <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_r == ST_RUN);
  assign packets_sent = packets_sent_r;

  assign axis_out.tdata       = tdata_r;
  assign axis_out.tkeep       = {64{1'b1}};
  assign axis_out.tlast       = tlast_r;
  assign axis_out.tvalid      = out_pend_r;

  assign axis_fifo_out.tdata  = tdata_r;
  assign axis_fifo_out.tkeep  = {64{1'b1}};
  assign axis_fifo_out.tlast  = tlast_r;
  assign axis_fifo_out.tvalid = fifo_pend_r;

endmodule
